cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cachepkg.sv | 30 +++
 rtl/cacheinterface.sv | 28 ++
 rtl/cache_lru.sv | 40 ++++
 rtl/cache.sv | 200 ++++++++++++++++++++
 tb/tb_cache.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cachepkg.sv
// Shared types for the set-associative write-back cache: FSM states, line
// layout and index/tag widths for the default 16-set, 32-bit-address build.
package cachepkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL,
        RESPOND
    } state_t;

    localparam int DEF_SETS   = 16;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_WORD_W = 8;
    localparam int INDEX_W    = $clog2(DEF_SETS);
    localparam int TAG_W      = DEF_ADDR_W - INDEX_W;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [TAG_W-1:0]      tag;
        logic [DEF_WORD_W-1:0] data;
    } line_t;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/cacheinterface.sv
// Request/response channel; the cache is the slave toward the CPU and the
// master toward the next memory level.
interface cacheinterface #(
    parameter type WORD      = logic [7:0],
    parameter type ADDRSPACE = logic [31:0]
) (
    input logic clock
);
    logic     req_valid;
    logic     req_write;
    ADDRSPACE req_addr;
    WORD      req_wdata;
    logic     req_ready;
    logic     resp_valid;
    WORD      resp_rdata;

    modport master (
        input  clock,
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  clock,
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/cache_lru.sv
// True-LRU age tracker: per set, each way holds an age (0 = MRU,
// WAYS-1 = LRU); ages always form a permutation of 0..WAYS-1.
module cache_lru #(
    parameter int SETS = 16,
    parameter int WAYS = 4,
    parameter int IW   = $clog2(SETS),
    parameter int WIW  = $clog2(WAYS)
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_upd,
    input  logic [IW-1:0]  i_set,
    input  logic [WIW-1:0] i_way,
    output logic [WIW-1:0] o_victim
);
    logic [WIW-1:0] r_age [SETS][WAYS];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= WIW'(w);
        end else if (i_upd) begin
            // Ways younger than the touched one age by one; touched way becomes MRU.
            for (int w = 0; w < WAYS; w++) begin
                if (WIW'(w) == i_way)
                    r_age[i_set][w] <= '0;
                else if (r_age[i_set][w] < r_age[i_set][i_way])
                    r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
            end
        end
    end

    always_comb begin
        o_victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_age[i_set][w] == WIW'(WAYS - 1))
                o_victim = WIW'(w);
    end
endmodule

// File: rtl/cache.sv
// WAYS-way set-associative, write-back, write-allocate cache with true LRU
// and a single outstanding request; one WORD per line.
module cache
    import cachepkg::*;
#(
    parameter type WORD      = logic [7:0],
    parameter type ADDRSPACE = logic [31:0],
    parameter int  SETS      = 16,
    parameter int  WAYS      = 4
) (
    input  logic          reset,
    cacheinterface.slave  cpu,
    cacheinterface.master nxt,
    output logic          hit,
    output logic          evict
);
    localparam int AW  = $bits(ADDRSPACE);
    localparam int IW  = index_w(SETS);
    localparam int TW  = AW - IW;
    localparam int WIW = $clog2(WAYS);

    typedef struct packed {
        logic          valid;
        logic          dirty;
        logic [TW-1:0] tag;
        WORD           data;
    } line_s;

    state_t               r_state, w_next;
    logic [SETS-1:0][WAYS-1:0] r_valid, r_dirty;
    logic [TW-1:0]        r_tag  [SETS][WAYS];
    WORD                  r_data [SETS][WAYS];
    logic                 r_write, r_sent;
    logic [AW-1:0]        r_addr, r_wb_addr;
    WORD                  r_wdata, r_rdata, r_nxt_wdata;
    logic [WIW-1:0]       r_way;

    logic [IW-1:0]        w_set;
    logic [TW-1:0]        w_tag;
    logic                 w_hit, w_inv;
    logic [WIW-1:0]       w_hit_way, w_inv_way, w_vic_way, w_lru_vic, w_lru_way;
    logic                 w_lru_upd;
    line_s                w_vic;
    logic                 w_req_ready, w_resp_valid, w_nxt_valid, w_nxt_write;
    logic [AW-1:0]        w_nxt_addr;
    WORD                  w_resp_rdata;
    logic                 w_fill_done;

    assign w_set       = r_addr[IW-1:0];
    assign w_tag       = r_addr[AW-1:IW];
    assign w_fill_done = (r_state == FILL) && r_sent && nxt.resp_valid;

    cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .i_clock  (cpu.clock),
        .i_reset  (reset),
        .i_upd    (w_lru_upd),
        .i_set    (w_set),
        .i_way    (w_lru_way),
        .o_victim (w_lru_vic)
    );

    // Descending scan so the lowest-index match/invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv     = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_set][w] && r_tag[w_set][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WIW'(w);
            end
            if (!r_valid[w_set][w]) begin
                w_inv     = 1'b1;
                w_inv_way = WIW'(w);
            end
        end
        w_vic_way  = w_inv ? w_inv_way : w_lru_vic;
        w_vic.valid = r_valid[w_set][w_vic_way];
        w_vic.dirty = r_dirty[w_set][w_vic_way];
        w_vic.tag   = r_tag[w_set][w_vic_way];
        w_vic.data  = r_data[w_set][w_vic_way];
    end

    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_rdata = r_rdata;
        w_nxt_valid  = 1'b0;
        w_nxt_write  = 1'b0;
        w_nxt_addr   = '0;
        hit          = 1'b0;
        evict        = 1'b0;
        w_lru_upd    = 1'b0;
        w_lru_way    = r_way;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (cpu.req_valid) w_next = COMPARE;
            end
            COMPARE: begin
                if (w_hit) begin
                    w_resp_valid = 1'b1;
                    w_resp_rdata = r_data[w_set][w_hit_way];
                    hit          = 1'b1;
                    w_lru_upd    = 1'b1;
                    w_lru_way    = w_hit_way;
                    w_next       = IDLE;
                end else begin
                    evict  = w_vic.valid;
                    w_next = (w_vic.valid && w_vic.dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                w_nxt_valid = 1'b1;
                w_nxt_write = 1'b1;
                w_nxt_addr  = r_wb_addr;
                if (nxt.req_ready) w_next = FILL;
            end
            FILL: begin
                if (!r_sent) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_addr  = r_addr;
                end else if (nxt.resp_valid) begin
                    w_next = RESPOND;
                end
            end
            RESPOND: begin
                w_resp_valid = 1'b1;
                w_resp_rdata = r_write ? r_wdata : r_data[w_set][r_way];
                w_lru_upd    = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge cpu.clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
            r_sent  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (cpu.req_valid) begin
                    r_write <= cpu.req_write;
                    r_addr  <= AW'(cpu.req_addr);
                    r_wdata <= cpu.req_wdata;
                end
                COMPARE: begin
                    if (w_hit) begin
                        if (r_write) r_dirty[w_set][w_hit_way] <= 1'b1;
                    end else begin
                        r_way     <= w_vic_way;
                        r_sent    <= 1'b0;
                        r_wb_addr <= {w_vic.tag, w_set};
                    end
                end
                FILL: begin
                    if (!r_sent) begin
                        if (nxt.req_ready) r_sent <= 1'b1;
                    end else if (nxt.resp_valid) begin
                        r_valid[w_set][r_way] <= 1'b1;
                        r_dirty[w_set][r_way] <= 1'b0;
                    end
                end
                RESPOND: if (r_write) r_dirty[w_set][r_way] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Line payload and held outputs carry no reset.
    always_ff @(posedge cpu.clock) begin
        if (!reset) begin
            if (r_state == COMPARE && w_hit && r_write)
                r_data[w_set][w_hit_way] <= r_wdata;
            if (w_fill_done) begin
                r_data[w_set][r_way] <= nxt.resp_rdata;
                r_tag[w_set][r_way]  <= w_tag;
            end
            if (r_state == RESPOND && r_write)
                r_data[w_set][r_way] <= r_wdata;
            if (r_state == COMPARE && !w_hit && w_vic.valid && w_vic.dirty)
                r_nxt_wdata <= w_vic.data;
        end
        if (w_resp_valid) r_rdata <= w_resp_rdata;
    end

    assign cpu.req_ready  = w_req_ready;
    assign cpu.resp_valid = w_resp_valid;
    assign cpu.resp_rdata = w_resp_rdata;
    assign nxt.req_valid  = w_nxt_valid;
    assign nxt.req_write  = w_nxt_write;
    assign nxt.req_addr   = ADDRSPACE'(w_nxt_addr);
    assign nxt.req_wdata  = r_nxt_wdata;
endmodule

// File: tb/tb_cache.sv
// Directed bench for the cache: the bench plays CPU and next level,
// stepping one negedge at a time, and compares against hand-worked values.
module tb_cache;
    import cachepkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic hit, evict;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    cacheinterface #(.WORD(logic [7:0]), .ADDRSPACE(logic [31:0])) cpu_if (.clock(clock));
    cacheinterface #(.WORD(logic [7:0]), .ADDRSPACE(logic [31:0])) nxt_if (.clock(clock));

    cache #(
        .WORD(logic [7:0]), .ADDRSPACE(logic [31:0]), .SETS(16), .WAYS(4)
    ) dut (
        .reset (reset),
        .cpu   (cpu_if),
        .nxt   (nxt_if),
        .hit   (hit),
        .evict (evict)
    );

    typedef struct {
        logic [7:0]  rd;
        int          lat;
        bit          resp, saw_hit, saw_evict, stable;
        int          nwr, nrd, stalls;
        logic [31:0] wb_addr, rd_addr;
        logic [7:0]  wb_data;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int tag, input int set);
        logic [31:0] t, s;
        t = 32'(tag);
        s = 32'(set);
        return {t[TAG_W-1:0], s[INDEX_W-1:0]};
    endfunction

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        cpu_if.req_valid = 1'b0;
        nxt_if.req_ready = 1'b0;
        nxt_if.resp_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One CPU access; the bench also serves next-level requests, holding
    // ready low for dly cycles per request and returning fdata a cycle later.
    task automatic access(input bit wr, input logic [31:0] a, input logic [7:0] d,
                          input logic [7:0] fdata, input int dly, input int budget,
                          input bit give_data, output res_t r);
        bit          rv_next = 1'b0;
        int          stall   = 0;
        logic [31:0] ra = '0;
        logic [7:0]  rdat = '0;
        logic        rw = 1'b0;
        r.rd = '0; r.lat = 0; r.resp = 0; r.saw_hit = 0; r.saw_evict = 0; r.stable = 1;
        r.nwr = 0; r.nrd = 0; r.stalls = 0; r.wb_addr = '0; r.rd_addr = '0; r.wb_data = '0;
        @(negedge clock);
        cpu_if.req_valid = 1'b1;
        cpu_if.req_write = wr;
        cpu_if.req_addr  = a;
        cpu_if.req_wdata = d;
        @(negedge clock);
        cpu_if.req_valid = 1'b0;
        for (int cyc = 1; cyc <= budget && !r.resp; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (hit)   r.saw_hit   = 1'b1;
            if (evict) r.saw_evict = 1'b1;
            if (cpu_if.resp_valid) begin
                r.resp = 1'b1;
                r.rd   = cpu_if.resp_rdata;
                r.lat  = cyc;
            end else if (cpu_if.req_ready) begin
                r.stable = 1'b0;
            end
            nxt_if.req_ready  = 1'b0;
            nxt_if.resp_valid = 1'b0;
            if (rv_next) begin
                nxt_if.resp_valid = 1'b1;
                nxt_if.resp_rdata = fdata;
                rv_next = 1'b0;
            end
            if (nxt_if.req_valid) begin
                if (stall == 0) begin
                    ra = nxt_if.req_addr; rdat = nxt_if.req_wdata; rw = nxt_if.req_write;
                end else if (nxt_if.req_addr !== ra || nxt_if.req_wdata !== rdat ||
                             nxt_if.req_write !== rw) begin
                    r.stable = 1'b0;
                end
                if (stall < dly) begin
                    stall++;
                    r.stalls++;
                end else begin
                    nxt_if.req_ready = 1'b1;
                    stall = 0;
                    if (nxt_if.req_write) begin
                        r.nwr++;
                        r.wb_addr = nxt_if.req_addr;
                        r.wb_data = nxt_if.req_wdata;
                    end else begin
                        r.nrd++;
                        r.rd_addr = nxt_if.req_addr;
                        rv_next   = give_data;
                    end
                end
            end
        end
        @(negedge clock);
        nxt_if.req_ready  = 1'b0;
        nxt_if.resp_valid = 1'b0;
    endtask

    initial begin
        res_t r;
        cpu_if.req_valid = 1'b0; cpu_if.req_write = 1'b0;
        cpu_if.req_addr  = '0;   cpu_if.req_wdata = '0;
        nxt_if.req_ready = 1'b0; nxt_if.resp_valid = 1'b0; nxt_if.resp_rdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_req_ready",  32'(cpu_if.req_ready), 1);
        chk("rst_resp_valid", 32'(cpu_if.resp_valid), 0);
        chk("rst_hit",        32'(hit), 0);
        chk("rst_evict",      32'(evict), 0);
        chk("rst_nxt_valid",  32'(nxt_if.req_valid), 0);

        // cold read miss, then hit
        access(1'b0, 32'h10, 8'h00, 8'hAB, 0, 50, 1'b1, r);
        chk("miss_resp",    32'(r.resp), 1);
        chk("miss_rdata",   32'(r.rd), 32'hAB);
        chk("miss_hit",     32'(r.saw_hit), 0);
        chk("miss_evict",   32'(r.saw_evict), 0);
        chk("miss_nrd",     r.nrd, 1);
        chk("miss_rd_addr", r.rd_addr, 32'h10);
        access(1'b0, 32'h10, 8'h00, 8'h00, 0, 50, 1'b1, r);
        chk("hit_latency",  r.lat, 1);
        chk("hit_flag",     32'(r.saw_hit), 1);
        chk("hit_rdata",    32'(r.rd), 32'hAB);
        chk("hit_no_nxt",   r.nrd + r.nwr, 0);

        // write-allocate miss into the next free way, then read it back
        access(1'b1, 32'h20, 8'h55, 8'h00, 0, 50, 1'b1, r);
        chk("wmiss_resp",   32'(r.resp), 1);
        chk("wmiss_evict",  32'(r.saw_evict), 0);
        chk("wmiss_nwr",    r.nwr, 0);
        access(1'b0, 32'h20, 8'h00, 8'h00, 0, 50, 1'b1, r);
        chk("wrd_rdata",    32'(r.rd), 32'h55);
        chk("wrd_hit",      32'(r.saw_hit), 1);
        chk("wrd_no_nxt",   r.nrd + r.nwr, 0);

        // fill set 0 with dirty lines; fifth evicts 0x0 under a stalled next level
        do_reset;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, addr_of(i, 0), 8'hA0 + 8'(i), 8'h00, 0, 50, 1'b1, r);
            chk("fill_no_evict", 32'(r.saw_evict), 0);
        end
        access(1'b1, 32'h40, 8'hA4, 8'h00, 5, 100, 1'b1, r);
        chk("ev_resp",      32'(r.resp), 1);
        chk("ev_evict",     32'(r.saw_evict), 1);
        chk("ev_nwr",       r.nwr, 1);
        chk("ev_wb_addr",   r.wb_addr, 32'h0);
        chk("ev_wb_data",   32'(r.wb_data), 32'hA0);
        chk("ev_rd_addr",   r.rd_addr, 32'h40);
        chk("ev_stable",    32'(r.stable), 1);
        chk("ev_stalls",    r.stalls, 10);
        access(1'b0, 32'h40, 8'h00, 8'h00, 0, 50, 1'b1, r);
        chk("ev_new_hit",   32'(r.saw_hit), 1);
        chk("ev_new_rdata", 32'(r.rd), 32'hA4);
        access(1'b0, 32'h0, 8'h00, 8'hA0, 0, 50, 1'b1, r);
        chk("ev2_hit",      32'(r.saw_hit), 0);
        chk("ev2_wb_addr",  r.wb_addr, 32'h10);
        chk("ev2_wb_data",  32'(r.wb_data), 32'hA1);
        chk("ev2_rdata",    32'(r.rd), 32'hA0);

        // re-touching the LRU line moves the victim to the next-oldest way
        do_reset;
        access(1'b0, 32'h10, 8'h00, 8'h11, 0, 50, 1'b1, r);
        access(1'b0, 32'h00, 8'h00, 8'h22, 0, 50, 1'b1, r);
        access(1'b0, 32'h20, 8'h00, 8'h33, 0, 50, 1'b1, r);
        access(1'b0, 32'h30, 8'h00, 8'h44, 0, 50, 1'b1, r);
        access(1'b0, 32'h10, 8'h00, 8'h00, 0, 50, 1'b1, r);
        chk("lru_touch_hit", 32'(r.saw_hit), 1);
        access(1'b0, 32'h40, 8'h00, 8'h55, 0, 50, 1'b1, r);
        chk("lru_evict",    32'(r.saw_evict), 1);
        chk("lru_clean_wb", r.nwr, 0);
        access(1'b0, 32'h10, 8'h00, 8'h00, 0, 50, 1'b1, r);
        chk("lru_keep_hit", 32'(r.saw_hit), 1);
        chk("lru_keep_rd",  32'(r.rd), 32'h11);
        access(1'b0, 32'h00, 8'h00, 8'h22, 0, 50, 1'b1, r);
        chk("lru_gone",     32'(r.saw_hit), 0);

        // reset during FILL aborts the access and invalidates everything
        do_reset;
        access(1'b0, 32'h20, 8'h00, 8'h66, 0, 50, 1'b1, r);
        access(1'b0, 32'h10, 8'h00, 8'h00, 0, 8, 1'b0, r);
        chk("abort_nrd",    r.nrd, 1);
        chk("abort_noresp", 32'(r.resp), 0);
        do_reset;
        chk("abort_rst_resp", 32'(cpu_if.resp_valid), 0);
        access(1'b0, 32'h20, 8'h00, 8'h66, 0, 50, 1'b1, r);
        chk("post_rst_miss20", 32'(r.saw_hit), 0);
        chk("post_rst_nrd20",  r.nrd, 1);
        access(1'b0, 32'h10, 8'h00, 8'h77, 0, 50, 1'b1, r);
        chk("post_rst_miss10", 32'(r.saw_hit), 0);
        chk("post_rst_rd10",   32'(r.rd), 32'h77);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
